// File: rtl/decoder_grant_arbiter.sv
// decoder_grant_arbiter: round-robin owner of an 8-way decoded resource.
// Drives the 3-bit select index plus its one-hot decode, gated by grant_valid.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req[7:0]        request vector, bit i = requester i
//   done            current owner releases (only sampled in GRANT)
//   grant_valid     a grant is active
//   grant_idx[2:0]  granted requester (hold value while idle)
//   grant_oh[7:0]   one-hot of grant_idx, zero when not granted
//   busy            FSM is in GRANT or GAP
module decoder_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic [7:0] grant_oh,
  output logic       busy
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          gv_q, gv_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    oh_q, oh_d;
  logic          busy_q, busy_d;

  logic          pick_vld;
  logic [2:0]    pick_idx;
  logic          rel;

  // Scan from ptr upward with wrap; iterating from the farthest
  // offset down lets the nearest set bit win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr_q + 3'(i)]) begin
        pick_vld = 1'b1;
        pick_idx = ptr_q + 3'(i);
      end
    end
  end

  // Any one of these ends the grant; coincident causes still give
  // a single release.
  assign rel = done
             | ~req[idx_q]
             | (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gv_d    = gv_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_GRANT;
          hold_d  = '0;
          gv_d    = 1'b1;
          idx_d   = pick_idx;
          oh_d    = 8'b1 << pick_idx;
          busy_d  = 1'b1;
        end
      end
      S_GRANT: begin
        if (rel) begin
          state_d = S_GAP;
          ptr_d   = idx_q + 3'd1;
          hold_d  = '0;
          gv_d    = 1'b0;
          oh_d    = 8'h00;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        gv_d    = 1'b0;
        oh_d    = 8'h00;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      hold_q  <= '0;
      gv_q    <= 1'b0;
      idx_q   <= 3'd0;
      oh_q    <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gv_q    <= gv_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_valid = gv_q;
  assign grant_idx   = idx_q;
  assign grant_oh    = oh_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// tb_decoder_grant_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the arbiter.
module tb_decoder_grant_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_oh;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // reference model
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_age;
  int m_gap;

  decoder_grant_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .grant_oh   (grant_oh),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // packed as {valid, idx, oh, busy}
  function automatic logic [12:0] st(
    input logic v, input int i,
    input logic [7:0] oh, input logic b);
    return {v, 3'(i), oh, b};
  endfunction

  function automatic logic [12:0] dut_st();
    return {grant_valid, grant_idx, grant_oh, busy};
  endfunction

  function automatic logic [12:0] m_st();
    logic [7:0] oh;
    oh = m_valid ? 8'(1 << m_idx) : 8'h00;
    return {m_valid, 3'(m_idx), oh, (m_valid || m_gap > 0)};
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_idx   = 0;
    m_ptr   = 0;
    m_age   = 0;
    m_gap   = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    int w;
    if (m_valid) begin
      m_age++;
      if (d || !r[m_idx] || m_age == MAXH) begin
        m_valid = 0;
        m_ptr   = (m_idx + 1) % 8;
        m_gap   = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (r != 8'h00) begin
      w = -1;
      for (int k = 0; k < 8; k++)
        if (w < 0 && r[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      m_idx   = w;
      m_valid = 1;
      m_age   = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(req, done);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cleanup();
    done = 1'b1;
    req  = 8'h00;
    tick();
    done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [12:0] e;
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    e = st(0, 0, 8'h00, 0);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL reset_held: got %h want %h", dut_st(), e);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (dut_st() !== e) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h want %h", i, dut_st(), e);
      end
    end
  endtask

  task automatic test_single();
    logic [12:0] e;
    req = 8'b0000_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = st(1, 2, 8'h04, 1);
      checks++;
      if (dut_st() !== e) begin
        errors++;
        $display("FAIL single_grant[%0d]: got %h want %h", i, dut_st(), e);
      end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    e = st(0, 2, 8'h00, 1);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL single_gap: got %h want %h", dut_st(), e);
    end
    tick();
    e = st(0, 2, 8'h00, 0);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL single_idle: got %h want %h", dut_st(), e);
    end
    tick();
    e = st(1, 2, 8'h04, 1);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL single_regrant: got %h want %h", dut_st(), e);
    end
    cleanup();
  endtask

  task automatic test_round_robin();
    logic [12:0] e;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      e = st(1, k % 8, 8'(1 << (k % 8)), 1);
      checks++;
      if (dut_st() !== e) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %h want %h", k, dut_st(), e);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      e = st(0, k % 8, 8'h00, 1);
      checks++;
      if (dut_st() !== e) begin
        errors++;
        $display("FAIL rr_gap[%0d]: got %h want %h", k, dut_st(), e);
      end
      tick();
      e = st(0, k % 8, 8'h00, 0);
      checks++;
      if (dut_st() !== e) begin
        errors++;
        $display("FAIL rr_idle[%0d]: got %h want %h", k, dut_st(), e);
      end
    end
    cleanup();
  endtask

  task automatic test_wrap();
    logic [12:0] e;
    int exp_seq [3] = '{7, 0, 7};
    do_reset();
    req = 8'h40;
    tick();
    e = st(1, 6, 8'h40, 1);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL wrap_g6: got %h want %h", dut_st(), e);
    end
    done = 1'b1;
    req  = 8'h00;
    tick();
    done = 1'b0;
    req  = 8'h81;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      e = st(1, exp_seq[k], 8'(1 << exp_seq[k]), 1);
      checks++;
      if (dut_st() !== e) begin
        errors++;
        $display("FAIL wrap_seq[%0d]: got %h want %h", k, dut_st(), e);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
    end
    cleanup();
  endtask

  task automatic test_timeout(input bit with_done);
    logic [12:0] e;
    do_reset();
    req = 8'h08;
    for (int i = 0; i < MAXH; i++) begin
      tick();
      e = st(1, 3, 8'h08, 1);
      checks++;
      if (dut_st() !== e) begin
        errors++;
        $display("FAIL timeout_hold[%0d,%0d]: got %h want %h",
                 with_done, i, dut_st(), e);
      end
    end
    done = with_done;
    tick();
    done = 1'b0;
    e = st(0, 3, 8'h00, 1);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL timeout_rel[%0d]: got %h want %h", with_done, dut_st(), e);
    end
    req = 8'h18;
    tick();
    e = st(0, 3, 8'h00, 0);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL timeout_idle[%0d]: got %h want %h", with_done, dut_st(), e);
    end
    tick();
    e = st(1, 4, 8'h10, 1);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL timeout_ptr[%0d]: got %h want %h", with_done, dut_st(), e);
    end
    cleanup();
  endtask

  task automatic test_midreset();
    logic [12:0] e;
    do_reset();
    req = 8'h20;
    tick();
    tick();
    e = st(1, 5, 8'h20, 1);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL midrst_grant: got %h want %h", dut_st(), e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    e = st(0, 0, 8'h00, 0);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL midrst_async: got %h want %h", dut_st(), e);
    end
    req = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 8'h21;
    tick();
    e = st(1, 0, 8'h01, 1);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL midrst_ptr0: got %h want %h", dut_st(), e);
    end
    cleanup();
  endtask

  task automatic test_withdraw();
    logic [12:0] e;
    req = 8'h20;
    tick();
    tick();
    e = st(1, 5, 8'h20, 1);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL withdraw_grant: got %h want %h", dut_st(), e);
    end
    req = 8'h00;
    tick();
    e = st(0, 5, 8'h00, 1);
    checks++;
    if (dut_st() !== e) begin
      errors++;
      $display("FAIL withdraw_rel: got %h want %h", dut_st(), e);
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [12:0] e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0)
        req = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      done = ($urandom_range(0, 5) == 0);
      tick();
      e = m_st();
      checks++;
      if (dut_st() !== e) begin
        errors++;
        $display("FAIL rand_model[%0d]: got %h want %h", c, dut_st(), e);
      end
      checks++;
      if (grant_oh != 8'h00 && !$onehot(grant_oh)) begin
        errors++;
        $display("FAIL rand_onehot[%0d]: got %h want 0 or onehot", c, grant_oh);
      end
      checks++;
      if (grant_valid && !grant_oh[grant_idx]) begin
        errors++;
        $display("FAIL rand_ohidx[%0d]: got oh %h idx %0d want bit set",
                 c, grant_oh, grant_idx);
      end
    end
    done = 1'b0;
    req  = 8'h00;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_midreset();
    test_withdraw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
